// File: rtl/bram_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bram_rr_arbiter_pkg
// Purpose  : Shared constants and helpers for the block-memory RR arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package bram_rr_arbiter_pkg;

   localparam int unsigned PORT0  = 0;
   localparam int unsigned PORT1  = 1;
   localparam int unsigned RL_MAX = 4;
   localparam int unsigned STAT_W = 16;

   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bram_rr_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter2
// Purpose  : Two-way round-robin arbiter; last served port loses a tie.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter2
   import bram_rr_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic r_last_grant;

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt[PORT0] = 1'b1;
         2'b10:   gnt[PORT1] = 1'b1;
         2'b11:   if (r_last_grant == 1'(PORT1)) gnt[PORT0] = 1'b1;
                  else                           gnt[PORT1] = 1'b1;
         default: gnt = 2'b00;
      endcase
   end

   // A grant always implies an accept, since gnt is only raised for a requester.
   always_ff @(posedge clk) begin
      if (rst)
         r_last_grant <= 1'(PORT1);
      else if (|gnt)
         r_last_grant <= gnt[PORT1];
   end

endmodule
`default_nettype wire

// File: rtl/bram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bram_rr_arbiter
// Purpose  : Two-requester RR sequencer for a single-port block memory with
//            per-requester read/write responses. Optional counters are
//            enabled by defining BRAM_ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bram_rr_arbiter
   import bram_rr_arbiter_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clka,
   input  logic                  rst,
   input  logic                  req0,
   input  logic [DATA_W/8-1:0]   we0,
   input  logic [ADDR_W-1:0]     addr0,
   input  logic [DATA_W-1:0]     wdata0,
   output logic                  gnt0,
   output logic                  rvalid0,
   output logic [DATA_W-1:0]     rdata0,
   input  logic                  req1,
   input  logic [DATA_W/8-1:0]   we1,
   input  logic [ADDR_W-1:0]     addr1,
   input  logic [DATA_W-1:0]     wdata1,
   output logic                  gnt1,
   output logic                  rvalid1,
   output logic [DATA_W-1:0]     rdata1,
   output logic [DATA_W/8-1:0]   mem_wea,
   output logic [ADDR_W-1:0]     mem_addra,
   output logic [DATA_W-1:0]     mem_dina,
`ifdef BRAM_ARB_STATS_EN
   output logic [STAT_W-1:0]     stat_gnt0,
   output logic [STAT_W-1:0]     stat_gnt1,
   output logic [STAT_W-1:0]     stat_conflict,
`endif
   input  logic [DATA_W-1:0]     mem_douta
);

   localparam int c_rl = (READ_LATENCY < 1) ? 1 :
                         (READ_LATENCY > int'(RL_MAX)) ? int'(RL_MAX) : READ_LATENCY;

   logic [1:0]        w_req;
   logic [1:0]        w_gnt;
   logic              w_acc;
   logic              w_own;
   logic              w_rv;
   logic              w_rown;
   logic [c_rl-1:0]   r_vld;
   logic [c_rl-1:0]   r_own;
   logic [DATA_W-1:0] r_rdata0;
   logic [DATA_W-1:0] r_rdata1;

   // Masking requests during reset keeps grants and memory drives quiet.
   assign w_req = rst ? 2'b00 : {req1, req0};

   rr_arbiter2 u_arb (
      .clk (clka),
      .rst (rst),
      .req (w_req),
      .gnt (w_gnt)
   );

   assign gnt0  = w_gnt[PORT0];
   assign gnt1  = w_gnt[PORT1];
   assign w_acc = |w_gnt;
   assign w_own = w_gnt[PORT1];

   always_comb begin
      mem_wea   = '0;
      mem_addra = '0;
      mem_dina  = '0;
      if (w_gnt[PORT0]) begin
         mem_wea   = we0;
         mem_addra = addr0;
         mem_dina  = wdata0;
      end else if (w_gnt[PORT1]) begin
         mem_wea   = we1;
         mem_addra = addr1;
         mem_dina  = wdata1;
      end
   end

   always_ff @(posedge clka) begin
      if (rst) begin
         r_vld <= '0;
         r_own <= '0;
      end else begin
         r_vld[0] <= w_acc;
         r_own[0] <= w_own;
         for (int i = 1; i < c_rl; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_own[i] <= r_own[i-1];
         end
      end
   end

   assign w_rv    = r_vld[c_rl-1] & ~rst;
   assign w_rown  = r_own[c_rl-1];
   assign rvalid0 = w_rv & ~w_rown;
   assign rvalid1 = w_rv &  w_rown;

   // Response data passes straight through from the memory and is held after.
   always_ff @(posedge clka) begin
      if (rst) begin
         r_rdata0 <= '0;
         r_rdata1 <= '0;
      end else begin
         if (rvalid0) r_rdata0 <= mem_douta;
         if (rvalid1) r_rdata1 <= mem_douta;
      end
   end

   assign rdata0 = rvalid0 ? mem_douta : r_rdata0;
   assign rdata1 = rvalid1 ? mem_douta : r_rdata1;

`ifdef BRAM_ARB_STATS_EN
   logic [STAT_W-1:0] r_stat_gnt0;
   logic [STAT_W-1:0] r_stat_gnt1;
   logic [STAT_W-1:0] r_stat_conflict;

   always_ff @(posedge clka) begin
      if (rst) begin
         r_stat_gnt0     <= '0;
         r_stat_gnt1     <= '0;
         r_stat_conflict <= '0;
      end else begin
         if (w_gnt[PORT0])  r_stat_gnt0     <= sat_inc(r_stat_gnt0);
         if (w_gnt[PORT1])  r_stat_gnt1     <= sat_inc(r_stat_gnt1);
         if (req0 && req1)  r_stat_conflict <= sat_inc(r_stat_conflict);
      end
   end

   assign stat_gnt0     = r_stat_gnt0;
   assign stat_gnt1     = r_stat_gnt1;
   assign stat_conflict = r_stat_conflict;
`endif

endmodule
`default_nettype wire
